// File: rtl/wfid_pool_allocator.sv
// rtl/wfid_pool_allocator.sv - wavefront slot ID allocator with internal vacancy pool and per-slot tag store
// Optional feature macro: WFID_ROUND_ROBIN_EN (round-robin search from a rotating pointer)
module wfid_pool_allocator #(
    parameter int NUM_WF    = 40,
    parameter int ID_WIDTH  = 6,
    parameter int TAG_WIDTH = 15,
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt,
    input  logic                 alloc_req,
    input  logic [TAG_WIDTH-1:0] alloc_tag,
    output logic                 alloc_gnt,
    output logic [ID_WIDTH-1:0]  alloc_id,
    input  logic                 free_valid,
    input  logic [ID_WIDTH-1:0]  free_id,
    output logic [TAG_WIDTH-1:0] free_tag,
    output logic                 free_tag_valid,
    output logic [NUM_WF-1:0]    vacant,
    output logic [CNT_WIDTH-1:0] occupied_cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 err_free
);

    logic [NUM_WF-1:0]    vacant_q, vacant_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 full_q, empty_q;
    logic [TAG_WIDTH-1:0] tag_store [NUM_WF];
    logic [ID_WIDTH-1:0]  enc_id;
    logic                 enc_found;
    logic                 free_in_range;
    logic                 free_ok;

`ifdef WFID_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] ptr_q;
    // ptr + offset can reach 2*NUM_WF-2, so one extra bit before the wrap
    logic [ID_WIDTH:0]   rr_idx;

    always_comb begin
        enc_id    = '0;
        enc_found = 1'b0;
        rr_idx    = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            rr_idx = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
            if (rr_idx >= (ID_WIDTH+1)'(NUM_WF))
                rr_idx = rr_idx - (ID_WIDTH+1)'(NUM_WF);
            if (!enc_found && vacant_q[rr_idx[ID_WIDTH-1:0]]) begin
                enc_found = 1'b1;
                enc_id    = rr_idx[ID_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (alloc_gnt) begin
            ptr_q <= (alloc_id == ID_WIDTH'(NUM_WF - 1)) ? '0 : alloc_id + ID_WIDTH'(1);
        end
    end
`else
    always_comb begin
        enc_id    = '0;
        enc_found = 1'b0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (!enc_found && vacant_q[i]) begin
                enc_found = 1'b1;
                enc_id    = ID_WIDTH'(i);
            end
        end
    end
`endif

    // Grant looks only at registered vacancy, so a slot freed this cycle is not reissued until next cycle
    assign alloc_gnt     = alloc_req & ~halt & ~full_q;
    assign alloc_id      = enc_id;
    assign free_in_range = (free_id < ID_WIDTH'(NUM_WF));
    assign free_ok       = free_valid & free_in_range & ~vacant_q[free_id];

    always_comb begin
        vacant_d = vacant_q;
        if (alloc_gnt)
            vacant_d[alloc_id] = 1'b0;
        if (free_ok)
            vacant_d[free_id] = 1'b1;
        case ({alloc_gnt, free_ok})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vacant_q       <= '1;
            cnt_q          <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            free_tag       <= '0;
            free_tag_valid <= 1'b0;
            err_free       <= 1'b0;
        end else begin
            vacant_q       <= vacant_d;
            cnt_q          <= cnt_d;
            full_q         <= (cnt_d == CNT_WIDTH'(NUM_WF));
            empty_q        <= (cnt_d == '0);
            free_tag_valid <= free_ok;
            err_free       <= free_valid & ~free_ok;
            if (free_ok)
                free_tag <= tag_store[free_id];
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_gnt)
            tag_store[alloc_id] <= alloc_tag;
    end

    assign vacant       = vacant_q;
    assign occupied_cnt = cnt_q;
    assign full         = full_q;
    assign empty        = empty_q;

endmodule

// File: tb/tb_wfid_pool_allocator.sv
// tb/tb_wfid_pool_allocator.sv - directed self-checking bench for wfid_pool_allocator with tag scoreboard
module tb_wfid_pool_allocator;
    localparam int NUM_WF    = 40;
    localparam int ID_WIDTH  = 6;
    localparam int TAG_WIDTH = 15;
    localparam int CNT_WIDTH = 7;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 halt = 1'b0;
    logic                 alloc_req = 1'b0;
    logic [TAG_WIDTH-1:0] alloc_tag = '0;
    logic                 alloc_gnt;
    logic [ID_WIDTH-1:0]  alloc_id;
    logic                 free_valid = 1'b0;
    logic [ID_WIDTH-1:0]  free_id = '0;
    logic [TAG_WIDTH-1:0] free_tag;
    logic                 free_tag_valid;
    logic [NUM_WF-1:0]    vacant;
    logic [CNT_WIDTH-1:0] occupied_cnt;
    logic                 full;
    logic                 empty;
    logic                 err_free;

    wfid_pool_allocator #(
        .NUM_WF(NUM_WF), .ID_WIDTH(ID_WIDTH), .TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .alloc_req(alloc_req), .alloc_tag(alloc_tag), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .free_valid(free_valid), .free_id(free_id), .free_tag(free_tag), .free_tag_valid(free_tag_valid),
        .vacant(vacant), .occupied_cnt(occupied_cnt), .full(full), .empty(empty), .err_free(err_free)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [NUM_WF-1:0]    m_vac;
    logic [TAG_WIDTH-1:0] m_tag [NUM_WF];
    logic [TAG_WIDTH-1:0] m_last_tag;
    logic [TAG_WIDTH-1:0] tag_q [$];
    int                   m_cnt;
    int                   m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vac      = '1;
        m_cnt      = 0;
        m_ptr      = 0;
        m_last_tag = '0;
        tag_q.delete();
    endtask

    function automatic int model_pick();
        for (int i = 0; i < NUM_WF; i++) begin
            int j;
            j = (m_ptr + i) % NUM_WF;
            if (m_vac[j]) return j;
        end
        return 0;
    endfunction

    task automatic check_state(input string where);
        check({where, ".vacant"}, 64'(vacant), 64'(m_vac));
        check({where, ".occupied_cnt"}, 64'(occupied_cnt), 64'(m_cnt));
        check({where, ".full"}, 64'(full), 64'(m_cnt == NUM_WF));
        check({where, ".empty"}, 64'(empty), 64'(m_cnt == 0));
    endtask

    // One clock of stimulus: comb grant checked before the edge, registered results after it
    task automatic cycle(input logic req, input logic [TAG_WIDTH-1:0] tag,
                         input logic fv, input logic [ID_WIDTH-1:0] fid, input logic h);
        logic exp_gnt;
        logic legal;
        logic exp_err;
        int   exp_id;
        logic [TAG_WIDTH-1:0] exp_tag;
        @(negedge clk);
        alloc_req  = req;
        alloc_tag  = tag;
        free_valid = fv;
        free_id    = fid;
        halt       = h;
        #1;
        exp_gnt = req && !h && (m_cnt != NUM_WF);
        exp_id  = model_pick();
        check("alloc_gnt", 64'(alloc_gnt), 64'(exp_gnt));
        check("alloc_id", 64'(alloc_id), 64'(exp_id));
        legal = fv && (int'(fid) < NUM_WF);
        if (legal) legal = !m_vac[fid];
        exp_err = fv && !legal;
        if (legal) begin
            tag_q.push_back(m_tag[fid]);
            m_vac[fid] = 1'b1;
            m_cnt--;
        end
        if (exp_gnt) begin
            m_vac[exp_id] = 1'b0;
            m_tag[exp_id] = tag;
            m_cnt++;
`ifdef WFID_ROUND_ROBIN_EN
            m_ptr = (exp_id + 1) % NUM_WF;
`endif
        end
        @(posedge clk);
        #1;
        check("free_tag_valid", 64'(free_tag_valid), 64'(legal));
        if (free_tag_valid === 1'b1) begin
            if (tag_q.size() == 0) begin
                check("free_tag_unexpected", 64'(free_tag_valid), 64'(0));
            end else begin
                exp_tag = tag_q.pop_front();
                check("free_tag", 64'(free_tag), 64'(exp_tag));
                m_last_tag = exp_tag;
            end
        end else begin
            check("free_tag_hold", 64'(free_tag), 64'(m_last_tag));
        end
        check("err_free", 64'(err_free), 64'(exp_err));
        check_state("post");
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NUM_WF; i++) m_tag[i] = '0;
        model_reset();

        #12;
        check_state("reset");
        check("reset.free_tag", 64'(free_tag), 64'(0));
        check("reset.free_tag_valid", 64'(free_tag_valid), 64'(0));
        check("reset.err_free", 64'(err_free), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Five allocations from an empty pool
        for (int i = 0; i < 5; i++)
            cycle(1'b1, TAG_WIDTH'(16'h100 + i), 1'b0, '0, 1'b0);
        check("five.occupied_cnt", 64'(occupied_cnt), 64'(5));
        check("five.vacant_low", 64'(vacant[4:0]), 64'(0));

        // Free slot 2, then reallocate
        cycle(1'b0, '0, 1'b1, ID_WIDTH'(2), 1'b0);
        check("free2.tag", 64'(free_tag), 64'(16'h102));
        cycle(1'b1, TAG_WIDTH'(16'h7ff), 1'b0, '0, 1'b0);

        // Fill to full, then collide a free with a request while full
        while (m_cnt < NUM_WF)
            cycle(1'b1, TAG_WIDTH'(16'h200 + m_cnt), 1'b0, '0, 1'b0);
        cycle(1'b1, TAG_WIDTH'(16'h300), 1'b0, '0, 1'b0);
        cycle(1'b1, TAG_WIDTH'(16'h301), 1'b1, ID_WIDTH'(17), 1'b0);
        cycle(1'b1, TAG_WIDTH'(16'h302), 1'b0, '0, 1'b0);
        check("refill.full", 64'(full), 64'(1));

        // Legal free of 3, then illegal frees: already vacant and out of range
        cycle(1'b0, '0, 1'b1, ID_WIDTH'(3), 1'b0);
        cycle(1'b0, '0, 1'b1, ID_WIDTH'(3), 1'b0);
        cycle(1'b0, '0, 1'b1, ID_WIDTH'(45), 1'b0);
        idle();

        // Halt blocks grants while a free still completes
        cycle(1'b1, TAG_WIDTH'(16'h400), 1'b0, '0, 1'b1);
        cycle(1'b1, TAG_WIDTH'(16'h401), 1'b1, ID_WIDTH'(10), 1'b1);
        cycle(1'b1, TAG_WIDTH'(16'h402), 1'b0, '0, 1'b1);
        idle();

        // Fresh pool with 10 occupied, then reset asynchronously with a free in flight
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++)
            cycle(1'b1, TAG_WIDTH'(16'h500 + i), 1'b0, '0, 1'b0);
        check("ten.occupied_cnt", 64'(occupied_cnt), 64'(10));
        @(negedge clk);
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_id    = ID_WIDTH'(4);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        check("async_rst.free_tag", 64'(free_tag), 64'(0));
        check("async_rst.err_free", 64'(err_free), 64'(0));
        @(posedge clk);
        #1;
        check("async_rst.free_tag_valid", 64'(free_tag_valid), 64'(0));
        @(negedge clk);
        free_valid = 1'b0;
        rst = 1'b1;
        cycle(1'b1, TAG_WIDTH'(16'h600), 1'b0, '0, 1'b0);
        check("after_rst.vacant0", 64'(vacant[0]), 64'(0));
        idle();

        check("scoreboard_drained", 64'(tag_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wfid_pool_allocator.md
Name: wfid_pool_allocator

Overview:
Parametrised wavefront-ID allocator with an internal vacancy pool. It hands out free wavefront slot IDs to the dispatcher together with a per-slot tag store. On wavefront completion it releases the slot and returns the stored tag. It holds vacancy state internally, replacing the old scheme where the vacancy vector was passed in externally, and adds occupancy counting, full/empty flags, and error detection for illegal frees.

Parameters:
NUM_WF, 40, number of wavefront slots (2..64)
ID_WIDTH, 6, width of slot ID; must satisfy 2^ID_WIDTH >= NUM_WF
TAG_WIDTH, 15, width of the dispatcher tag stored per slot
CNT_WIDTH, 7, width of the occupancy counter; must satisfy 2^CNT_WIDTH > NUM_WF

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
halt  in  1  blocks new allocations while high
alloc_req  in  1  dispatcher requests a slot this cycle
alloc_tag  in  TAG_WIDTH  tag to store against the granted slot
alloc_gnt  out  1  combinational grant
alloc_id  out  ID_WIDTH  granted slot ID, valid when alloc_gnt=1
free_valid  in  1  wavefront completion strobe
free_id  in  ID_WIDTH  slot being released
free_tag  out  TAG_WIDTH  tag of the released slot, registered
free_tag_valid  out  1  one-cycle pulse qualifying free_tag
vacant  out  NUM_WF  current vacancy vector, bit i=1 means slot i is free
occupied_cnt  out  CNT_WIDTH  number of occupied slots
full  out  1  occupied_cnt==NUM_WF
empty  out  1  occupied_cnt==0
err_free  out  1  one-cycle pulse on an illegal free

Behaviour:
- Reset (rst=0, asynchronous):
  - vacant = all ones; occupied_cnt=0; empty=1; full=0.
  - free_tag=0; free_tag_valid=0; err_free=0.
  - Search pointer = 0.
  - Tag store contents are don't-care.
- Allocation:
  - alloc_gnt = alloc_req & ~halt & ~full.
  - alloc_id = lowest-index set bit of the registered vacant vector (priority encoder). It is driven even when alloc_gnt=0. When full, alloc_id=0.
  - On a grant, at the clock edge: vacant[alloc_id] clears and tag_store[alloc_id] <= alloc_tag.
  - Zero-latency grant; the granted ID is occupied from the next cycle.
- Free:
  - A legal free is free_valid=1, free_id<NUM_WF, and vacant[free_id]=0.
  - On a legal free, at the edge: vacant[free_id] sets, free_tag <= tag_store[free_id], free_tag_valid=1 for one cycle.
  - Latency from free_valid to free_tag is 1 cycle.
  - An illegal free (out of range, or slot already vacant) changes no state, holds free_tag, leaves free_tag_valid=0, and sets err_free=1 next cycle.
- Simultaneous alloc and free:
  - Both take effect in the same edge.
  - A freed slot is not grantable in the same cycle, because the encoder sees registered vacancy. It becomes grantable next cycle.
  - alloc_id can never equal a legal free_id in the same cycle, since that slot is occupied.
  - Counter: +1 on grant, −1 on legal free, unchanged when both occur.
  - When full and a free occurs, alloc_gnt stays 0 that cycle; the grant can succeed next cycle.
- Halt:
  - Gates grants only.
  - Frees, tag readout and error detection continue during halt.
- occupied_cnt, full and empty are all registered and consistent with vacant at all times (popcount invariant).
- Reset mid-operation clears all occupancy immediately; in-flight frees are lost and no free_tag_valid pulse is emitted.

Optional Feature:
WFID_ROUND_ROBIN_EN
- Defined:
  - alloc_id is the first vacant slot at or after an internal search pointer, wrapping from NUM_WF−1 to 0.
  - On each grant the pointer <= alloc_id+1, wrapping to 0 at NUM_WF.
  - This spreads slot reuse.
- Undefined:
  - Fixed lowest-index priority as described above; no pointer register.

Test Plan:
- Reset, then alloc_req=1 with tags 0x100..0x104 for 5 cycles -> alloc_id 0,1,2,3,4; occupied_cnt=5; vacant[4:0]=0.
- Free id 2 -> next cycle free_tag=0x102 and free_tag_valid=1. Then alloc tag 0x7FF -> alloc_id=2 (round-robin build: alloc_id=5).
- Fill all 40 slots -> full=1 and alloc_gnt=0 with alloc_req=1. Free id 17 and alloc in the same cycle -> no grant that cycle; next cycle alloc_id=17 and full=1 again.
- Free id 3 while vacant, then free id 45 -> err_free pulses on both, occupied_cnt unchanged, free_tag_valid=0.
- halt=1 with alloc_req=1 for 3 cycles plus a legal free -> no grants, free tag returned, occupied_cnt decrements by 1.
- Assert rst=0 mid-cycle with 10 slots occupied -> outputs return to reset values asynchronously; first alloc after release gives id 0.
